// File: rtl/adder_pkg.sv
// adder_pkg: mode constants and geometry helpers for the pipelined adder.
//   MODE_ADD/MODE_SUB : encodings of the sub input
//   slice_w           : bits handled per pipeline stage
//   split_ok          : true when WIDTH divides evenly into STAGES slices
package adder_pkg;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;
    function automatic int slice_w(int width, int stages);
        return width / stages;
    endfunction
    function automatic bit split_ok(int width, int stages);
        return stages >= 1 && stages <= width && (width % stages) == 0;
    endfunction
endpackage

// File: rtl/adder_pipe_param_if.sv
// adder_pipe_param_if: operand/result bus of the pipelined adder.
//   input side : in_valid/in_ready handshake, op1, op2, cin, sub, tag_in
//   output side: out_valid/out_ready handshake, sum, cout, ovf, zero, tag_out
//   master drives operations and consumes results; slave is the adder
interface adder_pipe_param_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             cin;
    logic             sub;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic [TAG_W-1:0] tag_out;
    modport master (
        output in_valid, op1, op2, cin, sub, tag_in, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, tag_out
    );
    modport slave (
        input  in_valid, op1, op2, cin, sub, tag_in, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, tag_out
    );
endinterface

// File: rtl/adder_slice.sv
// adder_slice: combinational SW-bit ripple adder for one pipeline stage.
//   a, b, ci -> s, co ; c_msb_in is the carry into bit SW-1 (for signed overflow)
module adder_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co,
    output logic          c_msb_in
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};
    // the sum bit is a ^ b ^ carry-in, so the carry-in falls back out by xor
    assign c_msb_in = a[SW-1] ^ b[SW-1] ^ s[SW-1];
endmodule

// File: rtl/adder_pipe_param.sv
// adder_pipe_param: pipelined add/subtract with flags, tag sideband and full backpressure.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : adder_pipe_param_if slave (operation in, result out)
//   Stage k adds slice k of the operands; the carry, the remaining operand
//   slices, the finished low sum slices and the tag ride along with the op.
module adder_pipe_param
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input logic               clk,
    input logic               rst,
    adder_pipe_param_if.slave bus
);
    localparam int SW = slice_w(WIDTH, STAGES);
    localparam int L  = STAGES - 1;
    if (!split_ok(WIDTH, STAGES)) begin : g_bad
        $fatal(1, "adder_pipe_param: WIDTH must be a multiple of STAGES");
    end
    logic             v_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             ovf_q [STAGES];
    logic [TAG_W-1:0] t_q   [STAGES];
    logic             v_d   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] s_in  [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             c_in  [STAGES];
    logic [TAG_W-1:0] t_d   [STAGES];
    logic [SW-1:0]    s_w   [STAGES];
    logic             co_w  [STAGES];
    logic             cm_w  [STAGES];
    logic [STAGES:0]  rdy;
    // a stage can load when it is empty or its content moves on this cycle
    always_comb begin
        rdy[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) rdy[k] = !v_q[k] || rdy[k+1];
    end
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        if (k == 0) begin : g_in
            assign v_d[k]  = bus.in_valid;
            assign a_d[k]  = bus.op1;
            assign b_d[k]  = bus.sub == MODE_SUB ? ~bus.op2 : bus.op2;
            assign s_in[k] = '0;
            assign c_in[k] = bus.cin;
            assign t_d[k]  = bus.tag_in;
        end else begin : g_fwd
            assign v_d[k]  = v_q[k-1];
            assign a_d[k]  = a_q[k-1];
            assign b_d[k]  = b_q[k-1];
            assign s_in[k] = s_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign t_d[k]  = t_q[k-1];
        end
        adder_slice #(.SW(SW)) u_slice (
            .a        (a_d[k][k*SW +: SW]),
            .b        (b_d[k][k*SW +: SW]),
            .ci       (c_in[k]),
            .s        (s_w[k]),
            .co       (co_w[k]),
            .c_msb_in (cm_w[k])
        );
        // slices at and above k are still zero in s_in, so OR merges in place
        assign s_d[k] = s_in[k] | (WIDTH'(s_w[k]) << (k * SW));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                ovf_q[k] <= 1'b0;
                t_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= v_d[k];
                    if (v_d[k]) begin
                        a_q[k]   <= a_d[k];
                        b_q[k]   <= b_d[k];
                        s_q[k]   <= s_d[k];
                        c_q[k]   <= co_w[k];
                        ovf_q[k] <= cm_w[k] ^ co_w[k];
                        t_q[k]   <= t_d[k];
                    end
                end
            end
        end
    end
    // outputs are forced to zero whenever no result is presented
    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = v_q[L];
    assign bus.sum       = v_q[L] ? s_q[L] : '0;
    assign bus.cout      = v_q[L] && c_q[L];
    assign bus.ovf       = v_q[L] && ovf_q[L];
    assign bus.zero      = v_q[L] && s_q[L] == '0;
    assign bus.tag_out   = v_q[L] ? t_q[L] : '0;
endmodule

// File: tb/tb_adder_pipe_param.sv
// tb_adder_pipe_param: directed, table-driven and randomized checks of adder_pipe_param.
module tb_adder_pipe_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_s = 1'b1;
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    localparam int NOPS = 10000;
    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic [3:0]  tag;
    } res_t;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sb;
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;
    // reference: plain modular arithmetic, overflow from operand/result signs
    function automatic res_t model(int w, logic [63:0] a, logic [63:0] b, logic ci, logic sb, logic [3:0] tg);
        logic [63:0] mask;
        logic [64:0] full;
        res_t r;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = a & mask;
        b = (sb ? ~b : b) & mask;
        full = {1'b0, a} + {1'b0, b} + 65'(ci);
        r.sum = full[63:0] & mask;
        r.cout = full[w];
        r.ovf = (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
        r.zero = (r.sum == 64'd0);
        r.tag = tg;
        return r;
    endfunction
    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask
    task automatic chk_r(string nm, res_t got, res_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got sum=%h c=%b v=%b z=%b tag=%h expected sum=%h c=%b v=%b z=%b tag=%h",
                     nm, got.sum, got.cout, got.ovf, got.zero, got.tag,
                     exp.sum, exp.cout, exp.ovf, exp.zero, exp.tag);
        end
    endtask
    task automatic spurious(string nm, logic [3:0] tg);
        checks++;
        errors++;
        $display("FAIL %s: got delivery with tag=%h expected no delivery", nm, tg);
    endtask

    adder_pipe_param_if #(.WIDTH(32), .TAG_W(4)) m ();
    adder_pipe_param #(.WIDTH(32), .STAGES(4), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(m));

    res_t mq[$];
    res_t dq[$];
    int   dcyc[$];
    int   cyc_n = 0;
    logic s_acc, s_v, s_rdy;
    res_t s_out;

    function automatic res_t cur_m();
        res_t r;
        r.sum = 64'(m.sum);
        r.cout = m.cout;
        r.ovf = m.ovf;
        r.zero = m.zero;
        r.tag = m.tag_out;
        return r;
    endfunction
    // called at a falling edge with inputs set; samples, scores, advances one cycle
    task automatic tick();
        #1;
        s_acc = m.in_valid && m.in_ready;
        s_v = m.out_valid;
        s_rdy = m.in_ready;
        s_out = cur_m();
        if (s_acc) mq.push_back(model(32, 64'(m.op1), 64'(m.op2), m.cin, m.sub, m.tag_in));
        if (m.out_valid && m.out_ready) begin
            dq.push_back(s_out);
            dcyc.push_back(cyc_n);
            if (mq.size() == 0) spurious("sb_spurious", s_out.tag);
            else chk_r("sb", s_out, mq.pop_front());
        end
        cyc_n++;
        @(negedge clk);
    endtask
    task automatic drv(logic v, logic [31:0] a, logic [31:0] b, logic ci, logic sb, logic [3:0] tg);
        m.in_valid = v;
        m.op1 = a;
        m.op2 = b;
        m.cin = ci;
        m.sub = sb;
        m.tag_in = tg;
    endtask
    task automatic drv_rand(logic [3:0] tg);
        drv(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tg);
    endtask

    initial begin
        vec_t tv[9];
        int   nacc;
        logic hold;
        res_t hv;
        tv[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tv[1] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        tv[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        tv[3] = '{32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tv[4] = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        tv[5] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};
        tv[6] = '{32'h12345678, 32'h0000FFFF, 1'b0, 1'b0, 32'h12355677, 1'b0, 1'b0, 1'b0};
        tv[7] = '{32'h00000000, 32'h00000001, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        tv[8] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        drv(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
        m.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(m.out_valid), 64'd0);
        chk_r("rst_out", cur_m(), '0);
        rst = 1'b0;
        rst_s = 1'b0;
        m.out_ready = 1'b1;
        tick();
        chk("rdy_after_rst", 64'(s_rdy), 64'd1);
        // first-result latency and the carry-wrap case
        drv(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'h5);
        tick();
        chk("lat_acc", 64'(s_acc), 64'd1);
        m.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("lat_v%0d", i), 64'(s_v), 64'(i == 3));
            if (i == 3) chk_r("lat_res", s_out, '{64'd0, 1'b1, 1'b0, 1'b1, 4'h5});
        end
        // table vectors streamed back to back
        dq.delete();
        dcyc.delete();
        for (int i = 0; i < 9; i++) begin
            drv(1'b1, tv[i].a, tv[i].b, tv[i].ci, tv[i].sb, 4'(i));
            tick();
            chk("tv_acc", 64'(s_acc), 64'd1);
        end
        m.in_valid = 1'b0;
        repeat (6) tick();
        chk("tv_count", 64'(dq.size()), 64'd9);
        for (int i = 0; i < 9 && i < dq.size(); i++)
            chk_r($sformatf("tv%0d", i), dq[i], '{64'(tv[i].s), tv[i].co, tv[i].ov, tv[i].z, 4'(i)});
        // sixteen ops at full rate
        dq.delete();
        dcyc.delete();
        for (int t = 0; t < 16; t++) begin
            drv_rand(4'(t));
            tick();
            chk("st_acc", 64'(s_acc), 64'd1);
        end
        m.in_valid = 1'b0;
        repeat (6) tick();
        chk("st_count", 64'(dq.size()), 64'd16);
        for (int i = 0; i < dq.size(); i++) begin
            chk("st_tag", 64'(dq[i].tag), 64'(i % 16));
            chk("st_gap", 64'(dcyc[i] - dcyc[0]), 64'(i));
        end
        // backpressure: fill, hold, then release while still offering
        dq.delete();
        m.out_ready = 1'b0;
        nacc = 0;
        hold = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drv_rand(4'(nacc));
            tick();
            if (hold) chk_r("bp_hold", s_out, hv);
            hold = s_v;
            hv = s_out;
            if (s_acc) nacc++;
        end
        chk("bp_acc", 64'(nacc), 64'd4);
        chk("bp_rdy", 64'(s_rdy), 64'd0);
        chk("bp_valid", 64'(s_v), 64'd1);
        m.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drv_rand(4'(nacc));
            tick();
            chk("full_acc", 64'(s_acc), 64'd1);
            if (s_acc) nacc++;
        end
        m.in_valid = 1'b0;
        repeat (8) tick();
        chk("bp_count", 64'(dq.size()), 64'(nacc));
        for (int i = 0; i < dq.size(); i++) chk("bp_tag", 64'(dq[i].tag), 64'(i));
        // asynchronous reset with three ops in flight
        dq.delete();
        for (int t = 0; t < 3; t++) begin
            drv_rand(4'(t + 8));
            tick();
        end
        m.in_valid = 1'b0;
        tick();
        chk("rs_pre", 64'(m.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("rs_valid", 64'(m.out_valid), 64'd0);
        chk_r("rs_out", cur_m(), '0);
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rs_rdy", 64'(s_rdy), 64'd1);
        repeat (8) tick();
        chk("rs_stale", 64'(dq.size()), 64'd0);
        for (int i = 0; i < 60000 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done); i++)
            @(negedge clk);
        chk("sweep_done", 64'({g_sw[3].done, g_sw[2].done, g_sw[1].done, g_sw[0].done}), 64'hF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // parameter sweep: random traffic and backpressure against the queue model
    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int W = (g == 2) ? 64 : (g == 3) ? 8 : 32;
        localparam int S = (g == 0) ? 1 : (g == 1) ? 32 : (g == 2) ? 8 : 2;
        bit done = 1'b0;
        adder_pipe_param_if #(.WIDTH(W), .TAG_W(4)) sif ();
        adder_pipe_param #(.WIDTH(W), .STAGES(S), .TAG_W(4)) u_dut (.clk(clk), .rst(rst_s), .bus(sif));
        initial begin
            res_t q[$];
            res_t pv, cu;
            logic hold;
            int nacc;
            logic [63:0] r1, r2;
            hold = 1'b0;
            nacc = 0;
            sif.in_valid = 1'b0;
            sif.op1 = '0;
            sif.op2 = '0;
            sif.cin = 1'b0;
            sif.sub = 1'b0;
            sif.tag_in = '0;
            sif.out_ready = 1'b0;
            @(negedge clk);
            while (rst_s) @(negedge clk);
            for (int c = 0; c < 45000 && !(nacc >= NOPS && q.size() == 0); c++) begin
                r1 = {$urandom, $urandom};
                r2 = {$urandom, $urandom};
                if ($urandom_range(0, 7) == 0) r1 = '1;
                if ($urandom_range(0, 7) == 0) r2 = ($urandom_range(0, 1) == 1) ? 64'd1 : 64'd0;
                sif.in_valid = nacc < NOPS && $urandom_range(0, 3) != 0;
                sif.op1 = r1[W-1:0];
                sif.op2 = r2[W-1:0];
                sif.cin = 1'($urandom_range(0, 1));
                sif.sub = 1'($urandom_range(0, 1));
                sif.tag_in = 4'($urandom);
                sif.out_ready = nacc >= NOPS || $urandom_range(0, 3) != 0;
                #1;
                cu = {64'(sif.sum), sif.cout, sif.ovf, sif.zero, sif.tag_out};
                chk($sformatf("sw%0d_rdy", g), 64'(sif.in_ready), 64'(q.size() < S || sif.out_ready));
                if (hold) begin
                    chk($sformatf("sw%0d_hold_v", g), 64'(sif.out_valid), 64'd1);
                    chk_r($sformatf("sw%0d_hold", g), cu, pv);
                end
                if (!sif.out_valid) chk_r($sformatf("sw%0d_idle", g), cu, '0);
                if (sif.in_valid && sif.in_ready) begin
                    q.push_back(model(W, r1, r2, sif.cin, sif.sub, sif.tag_in));
                    nacc++;
                end
                if (sif.out_valid && sif.out_ready) begin
                    if (q.size() == 0) spurious($sformatf("sw%0d_spurious", g), cu.tag);
                    else chk_r($sformatf("sw%0d_res", g), cu, q.pop_front());
                end
                hold = sif.out_valid && !sif.out_ready;
                pv = cu;
                @(negedge clk);
            end
            chk($sformatf("sw%0d_ops", g), 64'(nacc), 64'(NOPS));
            chk($sformatf("sw%0d_drain", g), 64'(q.size()), 64'd0);
            done = 1'b1;
        end
    end
endmodule

// File: doc/adder_pipe_param.md
Name: adder_pipe_param

Overview:
Parametrised, pipelined two's-complement adder/subtractor for the datapath's arithmetic units. It is the successor to the flat 32-bit ripple adder.
- Width and pipeline depth are configurable. The carry chain is split into equal slices, one slice per stage.
- Adds an add/sub mode, status flags, and valid/ready handshakes on both sides with full backpressure.
- Sits between operand-fetch and writeback; a tag sideband travels with each operation so ordering can be checked.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline stages; slice width SW = WIDTH/STAGES; legal range 1..WIDTH.
- TAG_W, 4, width of the opaque sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation present on the input bus.
- in_ready  out  1  block can accept an operation this cycle.
- op1  in  WIDTH  operand A.
- op2  in  WIDTH  operand B.
- cin  in  1  carry-in (also used as the not-borrow-in for subtraction).
- sub  in  1  0 = add, 1 = subtract.
- tag_in  in  TAG_W  sideband value, returned unchanged.
- out_valid  out  1  result present on the output bus.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB.
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.
- tag_out  out  TAG_W  tag of the operation whose result is on the output.

Behaviour:
- Arithmetic: B' = sub ? ~op2 : op2. Full result = op1 + B' + cin, computed modulo 2^WIDTH.
  - Plain subtraction uses cin=1. cin=0 with sub=1 gives op1 - op2 - 1 (borrow-in).
- Flags:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - zero = (sum == 0).
  - All flags are produced in the last stage and valid only while out_valid=1.
- Pipeline: stage k (k = 0..STAGES-1) adds slice k (bits k*SW .. k*SW+SW-1) of op1 and B' using the carry registered by stage k-1; stage 0 uses cin.
  - Upper operand slices not yet consumed are registered forward with the operation.
  - Completed lower sum slices are registered forward with the operation.
  - tag is registered forward with the operation.
  - B' inversion is applied at input acceptance.
- Stage valid and ready:
  - Each stage has a valid bit, v[k].
  - ready[STAGES] = out_ready; ready[k] = !v[k] || ready[k+1]; in_ready = ready[0].
  - Stage k loads when ready[k] is high.
  - The combinational ready path is permitted; no skid buffer.
- Transfers: an accept happens on in_valid && in_ready; a delivery happens on out_valid && out_ready.
- Latency: with out_ready held high, an operation accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES register stages.
- Throughput: one operation per cycle sustained.
- Backpressure:
  - While out_ready=0, outputs hold stable.
  - The pipeline fills to STAGES entries, then in_ready=0.
  - No operation is dropped or duplicated, and order is strictly preserved.
- Simultaneous delivery and accept when full: allowed. The pipeline advances and stays full.
- Reset (asynchronous, any time, including mid-stream): all v[k] clear immediately.
  - out_valid=0, sum=0, cout=0, ovf=0, zero=0, tag_out=0.
  - in_ready=1 from the first cycle after rst deasserts.
  - Operations in flight are discarded.
- Datapath registers other than the valid bits may also reset to 0; outputs must read 0 while out_valid=0 after reset.
- STAGES=1 degenerates to a single registered adder with identical handshake rules.

Decomposition:
- Package adder_pkg:
  - ADD/SUB mode constants.
  - Function computing SW, and an elaboration-time check that WIDTH % STAGES == 0 (fatal otherwise).
- Sub-module adder_slice: combinational SW-bit ripple adder with ports a, b, ci → s, co, plus c_msb_in (carry into its top bit, used for ovf on the last slice).
  - Instantiated STAGES times in a generate loop.

Test Plan:
- WIDTH=32, STAGES=4, add 0xFFFFFFFF + 0x00000001, cin=0, out_ready=1 → sum=0x00000000, cout=1, zero=1, ovf=0; out_valid exactly 4 edges after accept.
- sub 0x80000000 - 0x00000001, cin=1 → sum=0x7FFFFFFF, cout=1, ovf=1, zero=0.
- Stream 16 ops, one per cycle, tags 0..15, out_ready=1 → 16 consecutive out_valid cycles, tags in order 0..15, results match the model.
- Stream with out_ready=0 for 10 cycles → exactly 4 accepted then in_ready=0, sum/tag_out stable. Release → remaining ops drain in order with none lost or duplicated.
- Assert rst for 1 cycle with 3 ops in flight → out_valid drops to 0 asynchronously with outputs 0; in_ready=1 the next cycle; no stale results ever delivered.
- Parameter sweep (WIDTH,STAGES) ∈ {(32,1),(32,32),(64,8),(8,2)}, 10k random ops with random in_valid/out_ready → every result, flag and tag matches the reference model, in order.
